// File: rtl/mipi_csi_packet_parser.sv
// CSI-2 packet parser: consumes lane-aligned 32-bit words from the lane aligner,
// validates the packet header ECC, tracks frame state from short packets and
// forwards long-packet payload as 32-bit words with a byte enable.
// One packet is parsed per HS burst; everything after it is discarded until
// data_valid_i drops.
module mipi_csi_packet_parser #(
  parameter bit         DT_FILTER_EN = 1'b0,
  parameter logic [5:0] DT_FILTER    = 6'h2B,
  parameter logic [1:0] VC_MATCH     = 2'd0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [3:0]  byte_en_o,
  output logic        output_valid_o,
  output logic [5:0]  data_type_o,
  output logic [15:0] word_count_o,
  output logic        frame_active_o,
  output logic        line_active_o,
  output logic        hdr_err_o,
  output logic        trunc_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PAYLOAD  = 2'd1,
    ST_WAIT_EOT = 2'd2
  } state_t;

  // Row masks of the CSI-2 header Hamming code; entry gi selects the header
  // bits that feed parity bit gi. Parity bits 7:6 are always zero.
  localparam logic [5:0][23:0] ECC_MASK = {
    24'hEFFC00,  // P5
    24'hDF03F0,  // P4
    24'hB8E38E,  // P3
    24'h749A6D,  // P2
    24'hF2555B,  // P1
    24'hF12CB7   // P0
  };

  localparam logic [5:0] DT_FRAME_START = 6'h00;
  localparam logic [5:0] DT_FRAME_END   = 6'h01;
  localparam logic [5:0] DT_SHORT_MAX   = 6'h0F;

  // Header field views of the incoming word
  logic [23:0] hdr_bits;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic [7:0]  hdr_ecc;
  logic [5:0]  ecc_calc;
  logic        ecc_ok;
  logic        hdr_is_short;
  logic        dt_accept;

  assign hdr_bits     = data_i[23:0];
  assign hdr_vc       = data_i[7:6];
  assign hdr_dt       = data_i[5:0];
  assign hdr_wc       = {data_i[23:16], data_i[15:8]};
  assign hdr_ecc      = data_i[31:24];
  assign hdr_is_short = (hdr_dt <= DT_SHORT_MAX);

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_ecc
      assign ecc_calc[gi] = ^(hdr_bits & ECC_MASK[gi]);
    end
  endgenerate

  // Detection only: any disagreement between received and computed ECC is an error
  assign ecc_ok = (hdr_ecc == {2'b00, ecc_calc});

  // Long packets only reach here; with filtering off every long DT is forwarded
  assign dt_accept = !DT_FILTER_EN || (hdr_dt == DT_FILTER);

  // Parser state and registered outputs
  state_t      state_q;
  logic [15:0] remaining_q;
  logic [31:0] data_q;
  logic [3:0]  byte_en_q;
  logic        output_valid_q;
  logic [5:0]  data_type_q;
  logic [15:0] word_count_q;
  logic        frame_active_q;
  logic        line_active_q;
  logic        hdr_err_q;
  logic        trunc_err_q;

  // Next-value helpers for the payload counter
  logic [15:0] remaining_d;
  logic [3:0]  last_be_d;

  assign remaining_d = remaining_q - 16'd4;
  // Thermometer of the 1..3 bytes left in the final, partial word
  assign last_be_d   = 4'((5'd1 << remaining_q[1:0]) - 5'd1);

  // Packet FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      remaining_q    <= 16'd0;
      data_q         <= 32'd0;
      byte_en_q      <= 4'd0;
      output_valid_q <= 1'b0;
      data_type_q    <= 6'd0;
      word_count_q   <= 16'd0;
      frame_active_q <= 1'b0;
      line_active_q  <= 1'b0;
      hdr_err_q      <= 1'b0;
      trunc_err_q    <= 1'b0;
    end else begin
      output_valid_q <= 1'b0;
      line_active_q  <= 1'b0;
      byte_en_q      <= 4'd0;
      hdr_err_q      <= 1'b0;
      trunc_err_q    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (data_valid_i) begin
            if (!ecc_ok) begin
              hdr_err_q <= 1'b1;
              state_q   <= ST_WAIT_EOT;
            end else if (hdr_vc != VC_MATCH) begin
              state_q <= ST_WAIT_EOT;
            end else if (hdr_is_short) begin
              if (hdr_dt == DT_FRAME_START) begin
                frame_active_q <= 1'b1;
              end else if (hdr_dt == DT_FRAME_END) begin
                frame_active_q <= 1'b0;
              end
              state_q <= ST_WAIT_EOT;
            end else begin
              data_type_q  <= hdr_dt;
              word_count_q <= hdr_wc;
              remaining_q  <= hdr_wc;
              if ((hdr_wc == 16'd0) || !dt_accept) begin
                state_q <= ST_WAIT_EOT;
              end else begin
                state_q <= ST_PAYLOAD;
              end
            end
          end
        end

        ST_PAYLOAD: begin
          if (data_valid_i) begin
            output_valid_q <= 1'b1;
            line_active_q  <= 1'b1;
            data_q         <= data_i;
            // Last-word test precedes the subtraction so the counter cannot wrap
            if (remaining_q < 16'd4) begin
              byte_en_q   <= last_be_d;
              remaining_q <= 16'd0;
              state_q     <= ST_WAIT_EOT;
            end else begin
              byte_en_q   <= 4'b1111;
              remaining_q <= remaining_d;
              if (remaining_q == 16'd4) begin
                state_q <= ST_WAIT_EOT;
              end
            end
          end else begin
            // Burst ended before the payload was complete
            trunc_err_q <= 1'b1;
            remaining_q <= 16'd0;
            state_q     <= ST_IDLE;
          end
        end

        ST_WAIT_EOT: begin
          if (!data_valid_i) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_o         = data_q;
  assign byte_en_o      = byte_en_q;
  assign output_valid_o = output_valid_q;
  assign data_type_o    = data_type_q;
  assign word_count_o   = word_count_q;
  assign frame_active_o = frame_active_q;
  assign line_active_o  = line_active_q;
  assign hdr_err_o      = hdr_err_q;
  assign trunc_err_o    = trunc_err_q;

endmodule

// File: tb/tb_mipi_csi_packet_parser.sv
// Bench for mipi_csi_packet_parser: two instances (DT filter on / off) share the
// input stream. Each HS burst is described as a list of words; a burst-level
// model derives the expected per-cycle outputs from the packet rules.
module tb_mipi_csi_packet_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [31:0] din;

  logic [31:0] dout [2];
  logic [3:0]  be   [2];
  logic        ov   [2];
  logic [5:0]  dt   [2];
  logic [15:0] wc   [2];
  logic        fa   [2];
  logic        la   [2];
  logic        he   [2];
  logic        te   [2];

  always #5 clk = ~clk;

  mipi_csi_packet_parser #(
    .DT_FILTER_EN (1'b1),
    .DT_FILTER    (6'h2B),
    .VC_MATCH     (2'd0)
  ) u_dut_filt (
    .clk_i          (clk),
    .reset_i        (rst),
    .data_valid_i   (dv),
    .data_i         (din),
    .data_o         (dout[0]),
    .byte_en_o      (be[0]),
    .output_valid_o (ov[0]),
    .data_type_o    (dt[0]),
    .word_count_o   (wc[0]),
    .frame_active_o (fa[0]),
    .line_active_o  (la[0]),
    .hdr_err_o      (he[0]),
    .trunc_err_o    (te[0])
  );

  mipi_csi_packet_parser #(
    .DT_FILTER_EN (1'b0),
    .DT_FILTER    (6'h2B),
    .VC_MATCH     (2'd0)
  ) u_dut_all (
    .clk_i          (clk),
    .reset_i        (rst),
    .data_valid_i   (dv),
    .data_i         (din),
    .data_o         (dout[1]),
    .byte_en_o      (be[1]),
    .output_valid_o (ov[1]),
    .data_type_o    (dt[1]),
    .word_count_o   (wc[1]),
    .frame_active_o (fa[1]),
    .line_active_o  (la[1]),
    .hdr_err_o      (he[1]),
    .trunc_err_o    (te[1])
  );

  // CSI-2 Hamming column codes: the parity contribution of each header bit
  localparam bit [5:0] ECC_CODE [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  typedef struct {
    bit        ov;
    bit [31:0] d;
    bit [3:0]  be;
    bit [5:0]  dt;
    bit [15:0] wc;
    bit        fa;
    bit        la;
    bit        he;
    bit        te;
  } exp_t;

  exp_t      ex [2][40];
  bit        m_fa [2];
  bit [5:0]  m_dt [2];
  bit [15:0] m_wc [2];
  bit [31:0] bw [32];

  int n_tests = 0;
  int n_fail  = 0;
  int n_burst = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [5:0] ecc_ref(input bit [23:0] h);
    bit [5:0] e = 6'd0;
    for (int i = 0; i < 24; i++) begin
      if (h[i]) e = e ^ ECC_CODE[i];
    end
    return e;
  endfunction

  function automatic bit [31:0] mk_hdr(input bit [1:0] vc, input bit [5:0] dtv, input bit [15:0] wcv);
    bit [23:0] h;
    h = {wcv, vc, dtv};
    return {2'b00, ecc_ref(h), h};
  endfunction

  // Expected outputs for every cycle of a burst of len words followed by an idle gap
  task automatic build_expect(input int len, input int total);
    bit [23:0] h;
    bit        ecc_good;
    bit [5:0]  hdt;
    bit [15:0] hwc;
    int        nwords;
    int        nout;
    for (int k = 0; k < 2; k++) begin
      bit fen;
      bit nfa;
      bit [5:0] ndt;
      bit [15:0] nwc;
      fen = (k == 0);
      h = bw[0][23:0];
      ecc_good = (bw[0][31:24] == {2'b00, ecc_ref(h)});
      hdt = h[5:0];
      hwc = h[23:8];
      nfa = m_fa[k];
      ndt = m_dt[k];
      nwc = m_wc[k];
      nwords = 0;
      nout = 0;
      if (ecc_good && h[7:6] == 2'd0) begin
        if (hdt < 6'h10) begin
          if (hdt == 6'h00) nfa = 1'b1;
          if (hdt == 6'h01) nfa = 1'b0;
        end else begin
          ndt = hdt;
          nwc = hwc;
          if (hwc != 0 && (!fen || hdt == 6'h2B)) begin
            nwords = (int'(hwc) + 3) / 4;
            nout = (len - 1 < nwords) ? len - 1 : nwords;
          end
        end
      end
      for (int t = 0; t < total; t++) begin
        ex[k][t] = '{default: 0};
        ex[k][t].fa = nfa;
        ex[k][t].dt = ndt;
        ex[k][t].wc = nwc;
      end
      if (!ecc_good) ex[k][0].he = 1'b1;
      for (int j = 1; j <= nout; j++) begin
        ex[k][j].ov = 1'b1;
        ex[k][j].la = 1'b1;
        ex[k][j].d  = bw[j];
        if (j == nwords && (hwc % 4) != 0)
          ex[k][j].be = 4'((1 << (hwc % 4)) - 1);
        else
          ex[k][j].be = 4'hF;
      end
      if (nwords > 0 && len - 1 < nwords) ex[k][len].te = 1'b1;
      m_fa[k] = nfa;
      m_dt[k] = ndt;
      m_wc[k] = nwc;
    end
  endtask

  task automatic check_cycle(input string name, input int t);
    for (int k = 0; k < 2; k++) begin
      string s;
      s = $sformatf("%s[dut%0d]@%0d", name, k, t);
      chk({s, ".valid"}, 32'(ov[k]), 32'(ex[k][t].ov));
      chk({s, ".line"},  32'(la[k]), 32'(ex[k][t].la));
      chk({s, ".hdr_err"}, 32'(he[k]), 32'(ex[k][t].he));
      chk({s, ".trunc"}, 32'(te[k]), 32'(ex[k][t].te));
      chk({s, ".frame"}, 32'(fa[k]), 32'(ex[k][t].fa));
      chk({s, ".dt"},    32'(dt[k]), 32'(ex[k][t].dt));
      chk({s, ".wc"},    32'(wc[k]), 32'(ex[k][t].wc));
      if (ex[k][t].ov) begin
        chk({s, ".data"}, dout[k], ex[k][t].d);
        chk({s, ".be"},   32'(be[k]), 32'(ex[k][t].be));
      end
    end
  endtask

  task automatic check_reset_state(input string name);
    for (int k = 0; k < 2; k++) begin
      string s;
      s = $sformatf("%s[dut%0d]", name, k);
      chk({s, ".data"},  dout[k], 32'd0);
      chk({s, ".be"},    32'(be[k]), 32'd0);
      chk({s, ".valid"}, 32'(ov[k]), 32'd0);
      chk({s, ".dt"},    32'(dt[k]), 32'd0);
      chk({s, ".wc"},    32'(wc[k]), 32'd0);
      chk({s, ".frame"}, 32'(fa[k]), 32'd0);
      chk({s, ".line"},  32'(la[k]), 32'd0);
      chk({s, ".hdr_err"}, 32'(he[k]), 32'd0);
      chk({s, ".trunc"}, 32'(te[k]), 32'd0);
    end
  endtask

  // Drive one burst (bw[0..len-1]) plus gap idle cycles; rst_at >= 0 pulses reset
  // asynchronously in the middle of that cycle instead of driving it
  task automatic run_burst(input string name, input int len, input int gap, input int rst_at);
    int total;
    total = len + gap;
    n_burst++;
    $display("[TB] burst %0d %s: hdr=%h len=%0d gap=%0d rst_at=%0d",
             n_burst, name, bw[0], len, gap, rst_at);
    build_expect(len, total);
    for (int t = 0; t < total; t++) begin
      @(negedge clk);
      if (t == rst_at) begin
        #2;
        rst = 1'b1;
        #1;
        check_reset_state({name, ".async_rst"});
        @(negedge clk);
        rst = 1'b0;
        dv  = 1'b0;
        for (int k = 0; k < 2; k++) begin
          m_fa[k] = 1'b0;
          m_dt[k] = 6'd0;
          m_wc[k] = 16'd0;
        end
        return;
      end
      dv  = (t < len);
      din = (t < len) ? bw[t] : $urandom;
      @(posedge clk);
      #1;
      check_cycle(name, t);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) bw[i] = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    dv  = 1'b0;
    din = 32'd0;
    for (int k = 0; k < 2; k++) begin
      m_fa[k] = 1'b0;
      m_dt[k] = 6'd0;
      m_wc[k] = 16'd0;
    end
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Frame Start / Frame End
    fill_random(); bw[0] = 32'h0000_0000;
    run_burst("frame_start", 1, 2, -1);
    fill_random(); bw[0] = mk_hdr(2'd0, 6'h01, 16'd0);
    run_burst("frame_end", 1, 2, -1);
    fill_random(); bw[0] = mk_hdr(2'd0, 6'h00, 16'd0);
    run_burst("frame_start2", 2, 1, -1);
    run_burst("frame_start_again", 1, 1, -1);

    // RAW10, WC multiple of 4, with trailing CRC word
    bw[0] = mk_hdr(2'd0, 6'h2B, 16'd8);
    bw[1] = 32'h0302_0100; bw[2] = 32'h0706_0504; bw[3] = 32'h0000_BEEF;
    run_burst("raw10_wc8", 4, 2, -1);

    fill_random(); bw[0] = mk_hdr(2'd0, 6'h2B, 16'd6);
    run_burst("raw10_wc6", 3, 2, -1);
    fill_random(); bw[0] = mk_hdr(2'd0, 6'h2B, 16'd5);
    run_burst("raw10_wc5", 4, 1, -1);
    fill_random(); bw[0] = mk_hdr(2'd0, 6'h2B, 16'd7);
    run_burst("raw10_wc7", 3, 1, -1);

    // Header error then recovery
    fill_random(); bw[0] = mk_hdr(2'd0, 6'h2B, 16'd8) ^ 32'h0000_0100;
    run_burst("hdr_err", 4, 2, -1);
    fill_random(); bw[0] = mk_hdr(2'd0, 6'h2B, 16'd4);
    run_burst("after_hdr_err", 3, 1, -1);

    // Truncation then recovery
    fill_random(); bw[0] = mk_hdr(2'd0, 6'h2B, 16'd16);
    run_burst("trunc", 3, 2, -1);
    fill_random(); bw[0] = mk_hdr(2'd0, 6'h2B, 16'd8);
    run_burst("after_trunc", 4, 1, -1);

    // Filter, VC and zero-length
    fill_random(); bw[0] = mk_hdr(2'd0, 6'h2A, 16'd8);
    run_burst("dt_2a", 4, 1, -1);
    fill_random(); bw[0] = mk_hdr(2'd1, 6'h2B, 16'd8);
    run_burst("vc1", 4, 1, -1);
    fill_random(); bw[0] = mk_hdr(2'd0, 6'h2B, 16'd0);
    run_burst("wc0", 2, 1, -1);

    // Reset mid-payload, then immediate restart
    fill_random(); bw[0] = mk_hdr(2'd0, 6'h2B, 16'd16);
    run_burst("rst_mid", 6, 1, 3);
    fill_random(); bw[0] = mk_hdr(2'd0, 6'h2B, 16'd12);
    run_burst("after_rst", 5, 1, -1);

    // Randomized bursts
    for (int n = 0; n < 300; n++) begin
      int kind;
      int wcv;
      int nwords;
      int len;
      int rst_at;
      string name;
      fill_random();
      kind = $urandom_range(0, 9);
      wcv = ($urandom_range(0, 15) == 0) ? $urandom_range(23, 65535) : $urandom_range(0, 22);
      nwords = (wcv + 3) / 4;
      if (nwords > 6) nwords = 6;
      len = 1 + nwords + $urandom_range(0, 2);
      case (kind)
        0: begin bw[0] = mk_hdr(2'd0, 6'h00, 16'(wcv)); name = "rnd_fs"; len = 1 + $urandom_range(0, 2); end
        1: begin bw[0] = mk_hdr(2'd0, 6'h01, 16'(wcv)); name = "rnd_fe"; len = 1 + $urandom_range(0, 2); end
        2: begin bw[0] = mk_hdr(2'd0, 6'($urandom_range(2, 15)), 16'(wcv)); name = "rnd_short"; len = 1 + $urandom_range(0, 2); end
        7: begin bw[0] = mk_hdr(2'd0, 6'($urandom_range(16, 63)), 16'(wcv)); name = "rnd_long_dt"; end
        8: begin bw[0] = mk_hdr(2'd0, 6'h2B, 16'(wcv)) ^ (32'd1 << $urandom_range(0, 31)); name = "rnd_bad_ecc"; end
        9: begin bw[0] = mk_hdr(2'($urandom_range(1, 3)), 6'h2B, 16'(wcv)); name = "rnd_vc"; end
        default: begin bw[0] = mk_hdr(2'd0, 6'h2B, 16'(wcv)); name = "rnd_raw10"; end
      endcase
      if ($urandom_range(0, 5) == 0) len = 1 + $urandom_range(0, nwords);
      rst_at = -1;
      if (len > 1 && $urandom_range(0, 39) == 0) rst_at = $urandom_range(1, len - 1);
      run_burst(name, len, $urandom_range(1, 3), rst_at);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
